// File: rtl/win_seq_pkg.sv
// ============================================================================
// Module   : win_seq_pkg
// Brief    : Shared types and defaults for the window frame sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package win_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic WIN_ROM = 1'b0;
  localparam logic WIN_RAM = 1'b1;

  localparam int FRAME_LEN_DEF = 256;
  localparam int PIPE_LAT_DEF  = 22;

endpackage

`default_nettype wire

// File: rtl/win_seq_delay_line.sv
// ============================================================================
// Module   : win_seq_delay_line
// Brief    : DEPTH-stage shift register, cleared to zero; flags any set bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module win_seq_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             occupied
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout     = stage[DEPTH-1];
  assign occupied = |stage;

endmodule

`default_nettype wire

// File: rtl/window_frame_sequencer.sv
// ============================================================================
// Module   : window_frame_sequencer
// Brief    : Frame tracking, window-source selection, coefficient read and
//            frame_last sequencing. Optional stall abort: WIN_SEQ_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module window_frame_sequencer
  import win_seq_pkg::*;
#(
  parameter int FRAME_LEN   = FRAME_LEN_DEF,
  parameter int ADDR_W      = 8,
  parameter int RD_LEAD     = 6,
  parameter int PIPE_LAT    = PIPE_LAT_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              sample_valid,
  input  logic              sel_ram_req,
  input  logic              sel_rom_req,
  input  logic              err_clr,
  output logic              rom_rd_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] coef_rd_addr,
  output logic              coef_valid,
  output logic              coef_sel_ram,
  output logic              frame_last,
  output logic              win_sel,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              overrun_err,
  output logic              timeout_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam int                RD_W     = ADDR_W + 2;

  if (FRAME_LEN < 2 || FRAME_LEN > (1 << ADDR_W) || RD_LEAD < 1 || RD_LEAD > 16 ||
      PIPE_LAT < 1 || PIPE_LAT > 64 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("window_frame_sequencer: parameter out of range");
  end

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              sel_pend;
  logic              abort;

  logic              in_run;
  logic              accept_idle;
  logic              launch;
  logic              launch_last;
  logic              accept_wrap;
  logic              overrun_set;
  logic [ADDR_W-1:0] launch_idx;
  logic              launch_sel;

  assign in_run      = (state == RUN);
  assign accept_idle = (state == IDLE) && frame_start;
  assign launch      = sample_valid && (in_run || accept_idle);
  assign launch_idx  = accept_idle ? '0 : idx;
  // The accepting cycle already uses the pending source for sample 0.
  assign launch_sel  = accept_idle ? sel_pend : win_sel;
  assign launch_last = launch && in_run && (idx == LAST_IDX);
  assign accept_wrap = launch_last && frame_start;
  assign overrun_set = in_run && frame_start && !accept_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      win_sel     <= WIN_ROM;
      sel_pend    <= WIN_ROM;
      overrun_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (sel_ram_req)      sel_pend <= WIN_RAM;
      else if (sel_rom_req) sel_pend <= WIN_ROM;

      if (overrun_set)  overrun_err <= 1'b1;
      else if (err_clr) overrun_err <= 1'b0;

      if (frame_last) frame_cnt <= frame_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            state   <= RUN;
            win_sel <= sel_pend;
            idx     <= sample_valid ? ADDR_W'(1) : '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            idx   <= '0;
          end else if (sample_valid) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (frame_start) win_sel <= sel_pend;
              else             state   <= IDLE;
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WIN_SEQ_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] stall_cnt;

  assign abort = in_run && !sample_valid && (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (sample_valid || !in_run) stall_cnt <= '0;
      else                         stall_cnt <= stall_cnt + STALL_W'(1);

      if (abort)        timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Idle cycles push zeros so the address field drains back to 0 as well.
  logic [RD_W-1:0] rd_din;
  logic [RD_W-1:0] rd_dout;
  logic            rd_valid;
  logic            rd_sel;
  logic            rd_occ;
  logic            last_occ;
  logic            coef_occ;

  assign rd_din = launch ? {1'b1, launch_sel, launch_idx} : '0;

  win_seq_delay_line #(
    .WIDTH (RD_W),
    .DEPTH (RD_LEAD)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (rd_din),
    .dout     (rd_dout),
    .occupied (rd_occ)
  );

  assign rd_valid     = rd_dout[RD_W-1];
  assign rd_sel       = rd_dout[RD_W-2];
  assign coef_rd_addr = rd_dout[ADDR_W-1:0];
  assign rom_rd_en    = rd_valid & ~rd_sel;
  assign ram_rd_en    = rd_valid & rd_sel;

  win_seq_delay_line #(
    .WIDTH (2),
    .DEPTH (1)
  ) u_coef_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      ({rd_valid, rd_valid & rd_sel}),
    .dout     ({coef_valid, coef_sel_ram}),
    .occupied (coef_occ)
  );

  win_seq_delay_line #(
    .WIDTH (1),
    .DEPTH (PIPE_LAT)
  ) u_last_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (launch_last),
    .dout     (frame_last),
    .occupied (last_occ)
  );

  assign busy = in_run | rd_occ | coef_occ | last_occ;

endmodule

`default_nettype wire

// File: tb/tb_window_frame_sequencer.sv
// ============================================================================
// Module   : tb_window_frame_sequencer
// Brief    : Directed, self-checking bench with a cycle-scheduled frame model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_window_frame_sequencer;

  localparam int FL = 256;
  localparam int AW = 8;
  localparam int RL = 6;
  localparam int PL = 22;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          sample_valid = 1'b0;
  logic          sel_ram_req = 1'b0;
  logic          sel_rom_req = 1'b0;
  logic          err_clr = 1'b0;
  logic          rom_rd_en;
  logic          ram_rd_en;
  logic [AW-1:0] coef_rd_addr;
  logic          coef_valid;
  logic          coef_sel_ram;
  logic          frame_last;
  logic          win_sel;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          overrun_err;
  logic          timeout_err;

  window_frame_sequencer #(
    .FRAME_LEN   (FL),
    .ADDR_W      (AW),
    .RD_LEAD     (RL),
    .PIPE_LAT    (PL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .sample_valid (sample_valid),
    .sel_ram_req  (sel_ram_req),
    .sel_rom_req  (sel_rom_req),
    .err_clr      (err_clr),
    .rom_rd_en    (rom_rd_en),
    .ram_rd_en    (ram_rd_en),
    .coef_rd_addr (coef_rd_addr),
    .coef_valid   (coef_valid),
    .coef_sel_ram (coef_sel_ram),
    .frame_last   (frame_last),
    .win_sel      (win_sel),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .overrun_err  (overrun_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Frame model: each accepted sample is scheduled as future output events.
  int       cyc = 0;
  bit       m_run, m_win, m_pend, m_over;
  int       m_idx, m_cnt;
  bit       m_ln, m_ls, m_lsel, m_ovr;
  int       m_lidx;
  bit [AW:0] exp_rd [int];
  bit        exp_coef [int];
  bit        exp_last [int];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_win = 0; m_pend = 0; m_over = 0; m_idx = 0; m_cnt = 0;
      exp_rd.delete(); exp_coef.delete(); exp_last.delete();
    end else begin
      m_ln = 0; m_ls = 0; m_lsel = 0; m_lidx = 0; m_ovr = 0;
      if (exp_last.exists(cyc)) m_cnt = m_cnt + 1;
      if (!m_run) begin
        if (frame_start) begin
          m_run = 1; m_win = m_pend; m_idx = 0;
          if (sample_valid) begin
            m_ln = 1; m_lidx = 0; m_lsel = m_win; m_idx = 1;
          end
        end
      end else begin
        if (frame_start && !(sample_valid && m_idx == FL - 1)) m_ovr = 1;
        if (sample_valid) begin
          m_ln = 1; m_lidx = m_idx; m_lsel = m_win; m_ls = (m_idx == FL - 1);
          if (m_ls) begin
            m_idx = 0;
            if (frame_start) m_win = m_pend;
            else             m_run = 0;
          end else begin
            m_idx = m_idx + 1;
          end
        end
      end
      if (m_ln) begin
        exp_rd[cyc + RL]       = {m_lsel, m_lidx[AW-1:0]};
        exp_coef[cyc + RL + 1] = m_lsel;
        if (m_ls) exp_last[cyc + PL] = 1'b1;
      end
      if (m_ovr)        m_over = 1;
      else if (err_clr) m_over = 0;
      if (sel_ram_req)      m_pend = 1;
      else if (sel_rom_req) m_pend = 0;
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison against the model, plus observation statistics.
  int rom_cycles = 0, ram_cycles = 0, first_rd = -1, wrap_seen = 0;
  int last_cycles [$];
  bit prev_rd = 0;
  int prev_addr = 0;
  bit e_v, e_sel, e_cv, e_cs, e_l;
  int e_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rom_rd_en", rom_rd_en, 0);
      chk("rst_ram_rd_en", ram_rd_en, 0);
      chk("rst_coef_valid", coef_valid, 0);
      chk("rst_frame_last", frame_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_win_sel", win_sel, 0);
      chk("rst_overrun", overrun_err, 0);
      prev_rd = 0;
    end else begin
      e_v = exp_rd.exists(cyc);
      e_sel = e_v ? exp_rd[cyc][AW] : 1'b0;
      e_addr = e_v ? int'(exp_rd[cyc][AW-1:0]) : 0;
      e_cv = exp_coef.exists(cyc);
      e_cs = e_cv ? exp_coef[cyc] : 1'b0;
      e_l = exp_last.exists(cyc);
      chk("rom_rd_en", rom_rd_en, e_v & ~e_sel);
      chk("ram_rd_en", ram_rd_en, e_v & e_sel);
      if (e_v) chk("coef_rd_addr", coef_rd_addr, e_addr);
      chk("coef_valid", coef_valid, e_cv);
      chk("coef_sel_ram", coef_sel_ram, e_cs);
      chk("frame_last", frame_last, e_l);
      chk("frame_cnt", frame_cnt, m_cnt & 16'hFFFF);
      chk("overrun_err", overrun_err, m_over);
      chk("win_sel", win_sel, m_win);

      if (rom_rd_en) rom_cycles++;
      if (ram_rd_en) ram_cycles++;
      if ((rom_rd_en || ram_rd_en) && first_rd < 0) first_rd = cyc;
      if ((rom_rd_en || ram_rd_en) && coef_rd_addr == 0 && prev_rd && prev_addr == FL - 1)
        wrap_seen++;
      if (frame_last) last_cycles.push_back(cyc);
      prev_rd = rom_rd_en || ram_rd_en;
      prev_addr = coef_rd_addr;
    end
  end

  task automatic drive(input bit fs, input bit sv, input bit ram, input bit rom, input bit clr);
    frame_start = fs; sample_valid = sv; sel_ram_req = ram; sel_rom_req = rom; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic samples(input int n);
    repeat (n) drive(0, 1, 0, 0, 0);
  endtask

  task automatic clr_stats();
    rom_cycles = 0; ram_cycles = 0; first_rd = -1; wrap_seen = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  int s, base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    chk("reset_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    idle(2);

    // Single ROM frame
    clr_stats(); base = last_cycles.size(); s = cyc;
    drive(1, 1, 0, 0, 0);
    chk("t1_busy_running", busy, 1);
    samples(FL - 1);
    idle(30);
    chk("t1_first_rd_cycle", first_rd, s + RL);
    chk("t1_rom_cycles", rom_cycles, 256);
    chk("t1_ram_cycles", ram_cycles, 0);
    chk("t1_last_count", last_cycles.size() - base, 1);
    if (last_cycles.size() > base) chk("t1_last_cycle", last_cycles[base], s + 255 + PL);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_busy_idle", busy, 0);

    // RAM request during a ROM frame takes effect on the next frame
    clr_stats();
    drive(1, 1, 0, 0, 0);
    samples(99);
    drive(0, 1, 1, 0, 0);
    samples(FL - 101);
    idle(30);
    chk("t2_f1_rom_cycles", rom_cycles, 256);
    chk("t2_f1_ram_cycles", ram_cycles, 0);
    chk("t2_win_sel_between", win_sel, 0);
    clr_stats();
    drive(1, 1, 0, 0, 0);
    chk("t2_win_sel_f2", win_sel, 1);
    samples(FL - 1);
    idle(30);
    chk("t2_f2_ram_cycles", ram_cycles, 256);
    chk("t2_f2_rom_cycles", rom_cycles, 0);
    chk("t2_frame_cnt", frame_cnt, 3);

    // Back-to-back frames
    clr_stats(); base = last_cycles.size(); s = cyc;
    drive(1, 1, 0, 0, 0);
    samples(FL - 2);
    drive(1, 1, 0, 0, 0);
    samples(FL);
    idle(30);
    chk("t3_wrap_seen", wrap_seen, 1);
    chk("t3_last_count", last_cycles.size() - base, 2);
    if (last_cycles.size() >= base + 2) begin
      chk("t3_last0_cycle", last_cycles[base], s + 255 + PL);
      chk("t3_last_spacing", last_cycles[base + 1] - last_cycles[base], 256);
    end
    chk("t3_overrun", overrun_err, 0);
    chk("t3_frame_cnt", frame_cnt, 5);

    // Stray frame_start mid-frame
    base = last_cycles.size();
    drive(1, 1, 0, 0, 0);
    samples(99);
    drive(1, 1, 0, 0, 0);
    chk("t4_overrun_set", overrun_err, 1);
    samples(FL - 101);
    idle(30);
    chk("t4_last_count", last_cycles.size() - base, 1);
    chk("t4_overrun_sticky", overrun_err, 1);
    drive(0, 0, 0, 0, 1);
    chk("t4_overrun_cleared", overrun_err, 0);

    // Reset in the middle of a frame
    base = last_cycles.size();
    drive(1, 1, 0, 0, 0);
    samples(49);
    frame_start = 0; sample_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("t5_rom_rd_en", rom_rd_en, 0);
    chk("t5_ram_rd_en", ram_rd_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_frame_cnt", frame_cnt, 0);
    chk("t5_win_sel", win_sel, 0);
    @(posedge clk); #1;
    idle(2);
    rst_n = 1'b1;
    idle(100);
    chk("t5_no_frame_last", last_cycles.size() - base, 0);
    chk("t5_frame_cnt_after", frame_cnt, 0);

`ifdef WIN_SEQ_TIMEOUT_EN
    // Stall mid-frame until the frame is abandoned
    base = last_cycles.size();
    drive(1, 1, 0, 0, 0);
    samples(10);
    idle(TO + 4);
    chk("t6_timeout_err", timeout_err, 1);
    chk("t6_busy", busy, 0);
    chk("t6_no_frame_last", last_cycles.size() - base, 0);
`else
    chk("t6_timeout_tied", timeout_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
